// File: rtl/ec_ladder_sched.sv
// Montgomery-ladder command scheduler: takes a big-endian scalar byte stream and
// issues a constant-time INIT / (ADD,DBL)* / FINAL command stream to the EC point engine.
module ec_ladder_sched #(
  parameter int unsigned KEY_BYTES = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_valid,
  output logic       key_ready,
  input  logic [7:0] key_byte,
  input  logic       key_last,
  output logic       op_valid,
  input  logic       op_ready,
  output logic [1:0] op_code,
  output logic       op_dst,
  input  logic       op_done,
  output logic       res_valid,
  input  logic       res_ready,
  output logic       err,
  output logic       busy
);
  localparam int unsigned NBITS = 8 * KEY_BYTES;
  localparam int unsigned IW    = $clog2(NBITS);
  localparam int unsigned CW    = $clog2(KEY_BYTES + 2);

  typedef enum logic [2:0] {S_LOAD, S_CHECK, S_ISSUE, S_WAIT, S_RESP} state_e;
  typedef enum logic [1:0] {PH_INIT = 2'b00, PH_ADD = 2'b01, PH_DBL = 2'b10, PH_FINAL = 2'b11} phase_e;

  state_e           state_q, state_d;
  phase_e           phase_q, phase_d;
  logic [NBITS-1:0] scalar_q, scalar_d;
  logic [CW-1:0]    count_q, count_d;
  logic [IW-1:0]    bit_idx_q, bit_idx_d;
  logic             err_q, err_d;
  logic             cur_bit;

  assign cur_bit = scalar_q[bit_idx_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_LOAD;
      phase_q   <= PH_INIT;
      scalar_q  <= '0;
      count_q   <= '0;
      bit_idx_q <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      scalar_q  <= scalar_d;
      count_q   <= count_d;
      bit_idx_q <= bit_idx_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    scalar_d  = scalar_q;
    count_d   = count_q;
    bit_idx_d = bit_idx_q;
    err_d     = err_q;
    unique case (state_q)
      S_LOAD: begin
        if (key_valid) begin
          // Excess bytes are still consumed so the stream drains up to key_last.
          if (count_q < CW'(KEY_BYTES)) scalar_d = {scalar_q[NBITS-9:0], key_byte};
          if (count_q != CW'(KEY_BYTES + 1)) count_d = count_q + CW'(1);
          if (key_last) state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((count_q != CW'(KEY_BYTES)) || (scalar_q == '0)) begin
          err_d    = 1'b1;
          scalar_d = '0;
          state_d  = S_RESP;
        end else begin
          bit_idx_d = IW'(NBITS - 1);
          phase_d   = PH_INIT;
          state_d   = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (op_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (op_done) begin
          state_d = S_ISSUE;
          unique case (phase_q)
            PH_INIT: phase_d = PH_ADD;
            PH_ADD:  phase_d = PH_DBL;
            PH_DBL: begin
              if (bit_idx_q == '0) begin
                phase_d = PH_FINAL;
              end else begin
                phase_d   = PH_ADD;
                bit_idx_d = bit_idx_q - IW'(1);
              end
            end
            PH_FINAL: state_d = S_RESP;
            default:  phase_d = PH_INIT;
          endcase
        end
      end
      S_RESP: begin
        if (res_ready) begin
          state_d  = S_LOAD;
          scalar_d = '0;
          count_d  = '0;
          err_d    = 1'b0;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_comb begin
    key_ready = 1'b0;
    op_valid  = 1'b0;
    op_code   = 2'b00;
    op_dst    = 1'b0;
    res_valid = 1'b0;
    unique case (state_q)
      S_LOAD: key_ready = 1'b1;
      S_ISSUE: begin
        op_valid = 1'b1;
        op_code  = phase_q;
        if (phase_q == PH_ADD)      op_dst = ~cur_bit;
        else if (phase_q == PH_DBL) op_dst = cur_bit;
      end
      S_RESP:  res_valid = 1'b1;
      default: ;
    endcase
  end

  assign err  = err_q;
  assign busy = (state_q != S_LOAD) || (count_q != '0);

endmodule

// File: tb/tb_ec_ladder_sched.sv
// Randomized bench for ec_ladder_sched: engine/consumer models drive the handshakes and
// every command, result and status output is checked against an expected op list.
module tb_ec_ladder_sched;
  localparam int unsigned KB = 32;

  logic       clk = 1'b0, rst = 1'b1;
  logic       key_valid = 1'b0, key_last = 1'b0;
  logic [7:0] key_byte = 8'h00;
  logic       op_ready = 1'b0, op_done = 1'b0, res_ready = 1'b0;
  logic       key_ready, op_valid, op_dst, res_valid, err, busy;
  logic [1:0] op_code;

  always #5 clk = ~clk;

  ec_ladder_sched #(.KEY_BYTES(KB)) dut (
    .clk(clk), .rst(rst),
    .key_valid(key_valid), .key_ready(key_ready), .key_byte(key_byte), .key_last(key_last),
    .op_valid(op_valid), .op_ready(op_ready), .op_code(op_code), .op_dst(op_dst), .op_done(op_done),
    .res_valid(res_valid), .res_ready(res_ready), .err(err), .busy(busy)
  );

  int n_cmp = 0, n_bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] kb[$];
  logic [2:0] exp_ops[$];
  logic       exp_err = 1'b0;
  int         exp_lat = -1, last_cyc = 0, meas_lat = 0, eng_lat = 3;
  bit         stall_mode = 0, chk_en = 0, job_active = 0, job_locked = 0;
  bit         res_seen = 0, prev_stall = 0;
  logic       res_err = 1'b0;
  logic [2:0] prev_fields = 3'b000;
  int         hs_cyc = -1000, hs_count = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic finish_bench();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  endtask

  // Expected command list from the ladder definition: INIT, per bit MSB..LSB (ADD ~b, DBL b), FINAL.
  task automatic build_model();
    logic [8*KB-1:0] s;
    s = '0;
    for (int i = 0; i < kb.size() && i < KB; i++) s = {s[8*KB-9:0], kb[i]};
    exp_ops.delete();
    exp_err = (kb.size() != KB) || (s == '0);
    if (!exp_err) begin
      exp_ops.push_back(3'b000);
      for (int b = 8*KB-1; b >= 0; b--) begin
        exp_ops.push_back({2'b01, ~s[b]});
        exp_ops.push_back({2'b10, s[b]});
      end
      exp_ops.push_back(3'b110);
    end
    if (exp_err)         exp_lat = 2;
    else if (stall_mode) exp_lat = -1;
    else                 exp_lat = 2 + exp_ops.size() * (eng_lat + 1);
  endtask

  task automatic send_key();
    int n;
    n = kb.size();
    for (int i = 0; i < n; i++) begin
      key_valid = 1'b1;
      key_byte  = kb[i];
      key_last  = (i == n - 1);
      @(posedge clk); #1;
      if (i == 0) job_active = 1;
      if (i == n - 1) begin
        job_locked = 1;
        last_cyc   = cyc - 1;
        build_model();
      end
    end
    key_valid = 1'b0;
    key_last  = 1'b0;
  endtask

  task automatic wait_result(input int hold);
    int w;
    w = 0;
    while (!res_valid) begin
      @(posedge clk); #1;
      w++;
      if (w > 20000) begin
        n_cmp++; n_bad++;
        $display("FAIL res_timeout: got no res_valid, expected it within 20000 cycles");
        finish_bench();
      end
    end
    repeat (hold) begin @(posedge clk); #1; end
    res_ready = 1'b1;
    @(posedge clk); #1;
    res_ready  = 1'b0;
    job_active = 0;
    job_locked = 0;
  endtask

  task automatic fill(input int n, input int kind);
    kb.delete();
    for (int i = 0; i < n; i++) begin
      case (kind)
        0: kb.push_back(8'h00);
        1: kb.push_back(8'hFF);
        default: kb.push_back(8'($urandom) | ((i == 0) ? 8'h01 : 8'h00));
      endcase
    end
  endtask

  // Engine model: done L cycles after each accepted command, random stalls and stray dones in ISSUE.
  always begin
    @(posedge clk); #1;
    op_ready = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    op_done  = (cyc == hs_cyc + eng_lat - 1) ||
               (stall_mode && op_valid && ($urandom_range(0, 3) == 0));
  end

  always @(negedge clk) begin
    if (rst) begin
      hs_cyc     = -1000;
      prev_stall = 0;
      res_seen   = 0;
    end else if (chk_en) begin
      chk("key_ready", key_ready, !job_locked);
      chk("busy", busy, job_active);
      if (prev_stall) chk("stall_hold", {op_valid, op_code, op_dst}, {1'b1, prev_fields});
      if (op_valid && op_ready) begin
        if (exp_ops.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL op_unexpected: got op %0h, expected no command", {op_code, op_dst});
        end else begin
          chk("op", {op_code, op_dst}, exp_ops.pop_front());
        end
        hs_cyc = cyc + 1;
        hs_count++;
      end
      prev_stall  = op_valid && !op_ready;
      prev_fields = {op_code, op_dst};
      if (res_valid) begin
        if (!job_locked) begin
          n_cmp++; n_bad++;
          $display("FAIL res_unexpected: got res_valid=1, expected 0");
        end else if (!res_seen) begin
          res_seen = 1;
          res_err  = err;
          meas_lat = cyc - last_cyc;
          chk("err", err, exp_err);
          chk("ops_left", exp_ops.size(), 0);
          if (exp_lat >= 0) chk("latency", meas_lat, exp_lat);
        end else begin
          chk("err_hold", err, res_err);
        end
      end else begin
        res_seen = 0;
      end
    end
  end

  initial begin
    int lat01, ops01, base, w;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_key_ready", key_ready, 1'b1);
    chk("rst_op_valid", op_valid, 1'b0);
    chk("rst_res_valid", res_valid, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_busy", busy, 1'b0);
    rst = 1'b0;
    chk_en = 1;
    @(posedge clk); #1;

    // Scalar 1, L=3: pin model against hand-derived sequence and timing.
    eng_lat = 3;
    fill(KB, 0); kb[KB-1] = 8'h01;
    base = hs_count;
    send_key();
    chk("model_nops", exp_ops.size(), 514);
    chk("model_op1", exp_ops[1], 3'b011);
    chk("model_op511", exp_ops[511], 3'b010);
    chk("model_op512", exp_ops[512], 3'b101);
    chk("model_op513", exp_ops[513], 3'b110);
    chk("model_lat", exp_lat, 2058);
    wait_result(0);
    lat01 = meas_lat;
    ops01 = hs_count - base;

    // All-ones scalar: same op count and duration.
    fill(KB, 1);
    base = hs_count;
    send_key();
    wait_result(0);
    chk("ct_latency", meas_lat, lat01);
    chk("ct_ops", hs_count - base, ops01);

    // Error cases: zero scalar, short key, long key.
    for (int t = 0; t < 3; t++) begin
      if (t == 0) fill(KB, 0);
      else if (t == 1) fill(KB - 1, 2);
      else fill(KB + 2, 2);
      base = hs_count;
      send_key();
      wait_result(0);
      chk("err_noops", hs_count - base, 0);
    end

    // Random scalars with stalls, stray dones and a slow consumer.
    for (int t = 0; t < 2; t++) begin
      stall_mode = 1;
      eng_lat = $urandom_range(1, 4);
      fill(KB, 2);
      send_key();
      wait_result(10);
      stall_mode = 0;
    end

    // Reset in the middle of the ladder at bit 100.
    eng_lat = 2;
    fill(KB, 2);
    base = hs_count;
    send_key();
    w = 0;
    while ((hs_count - base < 312) && (w < 20000)) begin @(posedge clk); #1; w++; end
    chk("reached_bit100", (hs_count - base) >= 312, 1'b1);
    rst = 1'b1;
    chk_en = 0;
    @(posedge clk); #1;
    chk("midrst_op_valid", op_valid, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_res_valid", res_valid, 1'b0);
    chk("midrst_key_ready", key_ready, 1'b1);
    rst = 1'b0;
    exp_ops.delete();
    job_active = 0;
    job_locked = 0;
    chk_en = 1;
    @(posedge clk); #1;

    // Scalar 2 after reset, L=2.
    fill(KB, 0); kb[KB-1] = 8'h02;
    send_key();
    chk("model2_op509", exp_ops[509], 3'b010);
    chk("model2_op511", exp_ops[511], 3'b011);
    chk("model2_lat", exp_lat, 1544);
    wait_result(0);

    // One more unstalled random job with random latency.
    eng_lat = $urandom_range(1, 4);
    fill(KB, 2);
    send_key();
    wait_result(3);

    repeat (3) @(posedge clk);
    finish_bench();
  end

endmodule

// File: doc/ec_ladder_sched.md
# ec_ladder_sched

Scheduler that turns a private-key scalar into a constant-time Montgomery-ladder command stream for the shared EC point engine, the hardware counterpart of deriving a public key from private-key bytes. It accepts the scalar as a big-endian byte stream, validates length and non-zero value, then issues INIT, 2×8×KEY_BYTES ladder ops and FINAL to the engine over a valid/ready + done interface, and reports completion or error. Sits between the key-import path and the point add/double engine; it owns no field arithmetic.

## Interface
- KEY_BYTES, 32, scalar length in bytes (curve key size); bit counter width = clog2(8*KEY_BYTES)
- clk  in  1  clock, all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- key_valid  in  1  scalar byte valid
- key_ready  out  1  scheduler accepts a byte
- key_byte  in  8  scalar byte, MSB-first (big-endian)
- key_last  in  1  final byte of scalar
- op_valid  out  1  engine command valid
- op_ready  in  1  engine accepts command
- op_code  out  2  00 INIT (R0=O, R1=G), 01 ADD (R[dst]=R0+R1), 10 DBL (R[dst]=2R[dst]), 11 FINAL (export R0 uncompressed)
- op_dst  out  1  ladder register index for ADD/DBL; 0 for INIT/FINAL
- op_done  in  1  one-cycle pulse, accepted command completed
- res_valid  out  1  job finished
- res_ready  in  1  consumer accepts result
- err  out  1  qualified by res_valid: 1 = bad length or zero scalar
- busy  out  1  high from first accepted byte until result handshake

## Operation
- States: LOAD, CHECK, ISSUE, WAIT, RESP.
- LOAD: key_ready=1; each key_valid&key_ready shifts byte into scalar register, byte count increments (saturating at KEY_BYTES+1). Bytes beyond KEY_BYTES are discarded but still accepted until key_last. key_last handshake -> CHECK.
- CHECK (1 cycle): err set if count != KEY_BYTES or scalar == 0. err -> RESP (no op issued); else bit_idx = 8*KEY_BYTES-1, phase = INIT -> ISSUE.
- ISSUE: op_valid=1, op_code/op_dst stable until op_ready. Handshake -> WAIT.
- WAIT: op_valid=0; op_done advances phase: INIT -> ADD; ADD -> DBL (same bit); DBL -> ADD with bit_idx-1, or FINAL when bit_idx==0; FINAL -> RESP. Otherwise -> ISSUE.
- Ladder per bit b = scalar[bit_idx]: ADD op_dst = ~b; DBL op_dst = b. Leading zero bits processed identically; op count and sequence timing independent of scalar value (constant-time).
- op_done outside WAIT ignored.
- RESP: res_valid=1, err held; on res_ready -> LOAD, scalar register and count cleared to 0 (zeroization). Scalar also cleared on err entry into RESP.

## Timing
- Reset: state LOAD, all outputs 0, scalar/count/bit_idx 0; key_ready=1 first cycle after rst deasserts.
- Byte intake: 1 byte/cycle; CHECK occupies the cycle after key_last handshake.
- First op_valid: 2 cycles after key_last handshake.
- Engine latency L>=1: handshake at t, op_done at t+L, next op_valid at t+L+1.
- Total ops on success: 16*KEY_BYTES+2 (514 for KEY_BYTES=32); with op_ready=1, key_last handshake to res_valid = 2 + (16*KEY_BYTES+2)*(L+1) cycles.
- res_valid held until res_ready; key_ready=0 throughout CHECK..RESP, returns 1 the cycle after result handshake (no byte accepted in the handshake cycle).
- rst mid-job: next cycle state LOAD, op_valid=0, res_valid=0, scalar zeroed; engine shares rst.

## Test plan
- KEY_BYTES=32, scalar 0x00…01, L=3, op_ready=1 -> INIT, 255×(ADD dst1, DBL dst0), ADD dst0, DBL dst1, FINAL; 514 ops; res_valid err=0 at 2+514×4 cycles after key_last.
- Scalar 0xFF…FF vs 0x00…01 -> identical op count and cycle count; only op_dst differs.
- 32 zero bytes -> op_valid never asserts; res_valid err=1 two cycles after key_last.
- key_last on byte 31, and separately 34 bytes -> all bytes accepted, err=1, no ops.
- Random op_ready stalls, spurious op_done in ISSUE, res_ready low 10 cycles -> command fields stable while stalled, spurious done ignored, res_valid/err held, key_ready=0.
- rst asserted at bit_idx=100 -> next cycle op_valid=0, busy=0; following scalar 0x00…02 completes with correct sequence.
